// File: rtl/sw_debounce_pkg.sv
// -----------------------------------------------------------------------------
// sw_debounce_pkg
// Shared types and constants for the switch debouncer.
//   state_t                  : per-channel debounce FSM state
//   DEBOUNCE_CYCLES_DEFAULT  : 1 ms at 12 MHz
//   DEBOUNCE_CYCLES_SIM      : short count for simulation
// -----------------------------------------------------------------------------
package sw_debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      RISE      = 2'd1,
      STABLE_HI = 2'd2,
      FALL      = 2'd3
   } state_t;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 12000;
   localparam int DEBOUNCE_CYCLES_SIM     = 4;

endpackage

// File: rtl/sw_debounce_if.sv
// -----------------------------------------------------------------------------
// sw_debounce_if
// Switch-side inputs and conditioned outputs of the debouncer.
//   sw_raw        : raw switch levels, asynchronous, 1 = pressed
//   sw_level      : debounced level per channel
//   sw_press      : one-cycle pulse on accepted 0->1
//   sw_release    : one-cycle pulse on accepted 1->0 (SW_DEBOUNCE_RELEASE_EN)
//   sw_any_press  : OR of sw_press, same cycle
// Modports: master = debouncer, slave = switch pins / downstream consumer.
// -----------------------------------------------------------------------------
interface sw_debounce_if #(
   parameter int N_SW = 4
);
   logic [N_SW-1:0] sw_raw;
   logic [N_SW-1:0] sw_level;
   logic [N_SW-1:0] sw_press;
`ifdef SW_DEBOUNCE_RELEASE_EN
   logic [N_SW-1:0] sw_release;
`endif
   logic            sw_any_press;

   modport master (
      input  sw_raw,
      output sw_level,
      output sw_press,
`ifdef SW_DEBOUNCE_RELEASE_EN
      output sw_release,
`endif
      output sw_any_press
   );

   modport slave (
      output sw_raw,
      input  sw_level,
      input  sw_press,
`ifdef SW_DEBOUNCE_RELEASE_EN
      input  sw_release,
`endif
      input  sw_any_press
   );
endinterface

// File: rtl/sw_debounce_chan.sv
// -----------------------------------------------------------------------------
// sw_debounce_chan
// One switch channel: 2-flop synchroniser, 4-state debounce FSM, counter,
// registered level and event pulses.
//   clk, rst_n  : clock, asynchronous active-low reset
//   raw         : raw switch level (asynchronous)
//   level       : debounced level (registered)
//   press       : one-cycle pulse on accepted 0->1 (registered)
//   rel         : one-cycle pulse on accepted 1->0 (SW_DEBOUNCE_RELEASE_EN)
//   press_nxt   : next-cycle value of press, for the shared any-press flop
// -----------------------------------------------------------------------------
module sw_debounce_chan
   import sw_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press,
`ifdef SW_DEBOUNCE_RELEASE_EN
   output logic rel,
`endif
   output logic press_nxt
);

   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             sync;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
`ifdef SW_DEBOUNCE_RELEASE_EN
   logic             rel_q, rel_d;
`endif

   assign sync = sync_q[1];

   // NOTE: every flop here, synchroniser included, takes the async reset so a
   // reset discards any pending count and leaves no stale sample behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
`ifdef SW_DEBOUNCE_RELEASE_EN
         rel_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values.
         sync_q  <= {sync_q[0], raw};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
`ifdef SW_DEBOUNCE_RELEASE_EN
         rel_q   <= rel_d;
`endif
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
`ifdef SW_DEBOUNCE_RELEASE_EN
      rel_d   = 1'b0;
`endif
      unique case (state_q)
         STABLE_LO: begin
            if (sync) begin
               state_d = RISE;
               cnt_d   = CNT_W'(1);
            end
         end
         RISE: begin
            if (!sync) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STABLE_HI: begin
            if (!sync) begin
               state_d = FALL;
               cnt_d   = CNT_W'(1);
            end
         end
         FALL: begin
            if (sync) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               level_d = 1'b0;
`ifdef SW_DEBOUNCE_RELEASE_EN
               rel_d   = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   assign level     = level_q;
   assign press     = press_q;
`ifdef SW_DEBOUNCE_RELEASE_EN
   assign rel       = rel_q;
`endif
   assign press_nxt = press_d;

endmodule

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Synchronises and debounces N_SW switch inputs, producing clean levels and
// one-cycle press (and optionally release) events.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sw_debounce_if.master (sw_raw in; sw_level, sw_press,
//            sw_release, sw_any_press out)
// Build option: define SW_DEBOUNCE_RELEASE_EN to add sw_release and its logic.
// -----------------------------------------------------------------------------
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int N_SW            = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   sw_debounce_if.master   bus
);

   logic [N_SW-1:0] level_v;
   logic [N_SW-1:0] press_v;
   logic [N_SW-1:0] press_nxt_v;
`ifdef SW_DEBOUNCE_RELEASE_EN
   logic [N_SW-1:0] rel_v;
`endif
   logic            any_press_q;

   for (genvar g = 0; g < N_SW; g++) begin : g_chan
      sw_debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .raw       (bus.sw_raw[g]),
         .level     (level_v[g]),
         .press     (press_v[g]),
`ifdef SW_DEBOUNCE_RELEASE_EN
         .rel       (rel_v[g]),
`endif
         .press_nxt (press_nxt_v[g])
      );
   end

   // Registered from the channels' next-press terms so it lines up with the
   // per-channel pulses instead of trailing them by a cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) any_press_q <= 1'b0;
      else        any_press_q <= |press_nxt_v;
   end

   assign bus.sw_level     = level_v;
   assign bus.sw_press     = press_v;
`ifdef SW_DEBOUNCE_RELEASE_EN
   assign bus.sw_release   = rel_v;
`endif
   assign bus.sw_any_press = any_press_q;

endmodule

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
// Scoreboard bench for sw_debounce with DEBOUNCE_CYCLES_SIM. Each stimulus
// step pushes the event it must cause (cycle, press/release masks, resulting
// level); a negedge monitor pops it on that cycle and checks all outputs,
// expecting quiet outputs on every other cycle.
// -----------------------------------------------------------------------------
module tb_sw_debounce;
   import sw_debounce_pkg::*;

   localparam int N   = 4;
   localparam int D   = DEBOUNCE_CYCLES_SIM;
   localparam int LAT = D + 1;   // edges after the first sampling edge

   typedef struct {
      int       cyc;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] level;
   } evt_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;
   evt_t sb_q[$];
   logic [3:0] cur_level = '0;

   sw_debounce_if #(.N_SW(N)) bus ();

   sw_debounce #(
      .N_SW            (N),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Called right after a negedge: the first edge to sample the new value is cyc+1.
   task automatic drive(input logic [3:0] v);
      bus.sw_raw = v;
   endtask

   task automatic expect_evt(input logic [3:0] p, input logic [3:0] r, input logic [3:0] lvl);
      evt_t e;
      e.cyc   = cyc + 1 + LAT;
      e.press = p;
      e.rel   = r;
      e.level = lvl;
      sb_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic monitor();
      logic [3:0] ep;
      logic [3:0] er;
      evt_t e;
      ep = '0;
      er = '0;
      if (!rst_n) begin
         cur_level = '0;
         check("rst_level", 32'(bus.sw_level), 32'(0));
         check("rst_press", 32'(bus.sw_press), 32'(0));
         check("rst_any",   32'(bus.sw_any_press), 32'(0));
`ifdef SW_DEBOUNCE_RELEASE_EN
         check("rst_release", 32'(bus.sw_release), 32'(0));
`endif
      end else begin
         if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc != cyc) check("sb_late", 32'(cyc), 32'(e.cyc));
            ep        = e.press;
            er        = e.rel;
            cur_level = e.level;
         end
         check("press", 32'(bus.sw_press), 32'(ep));
         check("any_press", 32'(bus.sw_any_press), 32'(|ep));
         check("level", 32'(bus.sw_level), 32'(cur_level));
`ifdef SW_DEBOUNCE_RELEASE_EN
         check("release", 32'(bus.sw_release), 32'(er));
`endif
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         monitor();
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.sw_raw = 4'hF;
      #1 rst_n = 1'b0;
      wait_cyc(3);

      // Reset release with all switches held: debounce from scratch, press all.
      rst_n = 1'b1;
      expect_evt(4'hF, 4'h0, 4'hF);
      wait_cyc(12);

      // SW3/SW4 fall together.
      drive(4'b0011);
      expect_evt(4'h0, 4'b1100, 4'b0011);
      wait_cyc(12);

      drive(4'b0000);
      expect_evt(4'h0, 4'b0011, 4'b0000);
      wait_cyc(12);

      // Clean press and release on channel 0.
      drive(4'b0001);
      expect_evt(4'b0001, 4'h0, 4'b0001);
      wait_cyc(10);
      drive(4'b0000);
      expect_evt(4'h0, 4'b0001, 4'b0000);
      wait_cyc(12);

      // Bounce on channel 1: high 3, low 1, high 10.
      drive(4'b0010);
      wait_cyc(3);
      drive(4'b0000);
      wait_cyc(1);
      drive(4'b0010);
      expect_evt(4'b0010, 4'h0, 4'b0010);
      wait_cyc(10);
      drive(4'b0000);
      expect_evt(4'h0, 4'b0010, 4'b0000);
      wait_cyc(12);

      // Short glitch on channel 2: must produce nothing.
      drive(4'b0100);
      wait_cyc(3);
      drive(4'b0000);
      wait_cyc(12);

      // Simultaneous press on channels 0 and 3.
      drive(4'b1001);
      expect_evt(4'b1001, 4'h0, 4'b1001);
      wait_cyc(12);

      // Channel 1 rises; reset lands mid-cycle while it sits in RISE with cnt=2.
      drive(4'b1011);
      wait_cyc(4);
      #2 rst_n = 1'b0;
      #1;
      check("async_level", 32'(bus.sw_level), 32'(0));
      check("async_press", 32'(bus.sw_press), 32'(0));
      check("async_any",   32'(bus.sw_any_press), 32'(0));
      drive(4'b0000);
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(15);

      check("sb_empty", 32'(sb_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
